seq_det_prog: RTL

SEQ_DET_PROG -- requirements
Module: seq_det_prog

---
 rtl/seq_det_pkg.sv | 22 ++
 rtl/seq_det_prog_sat_counter.sv | 18 +
 rtl/seq_det_prog.sv | 79 +++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants and the pattern-length clamp for the programmable sequence detector.
package seq_det_pkg;

  localparam logic MODE_OVL  = 1'b1;
  localparam logic MODE_NOVL = 1'b0;
  localparam int   LEN_MIN   = 2;
  localparam int   PAT_W_DEF = 8;
  localparam int   CNT_W_DEF = 8;

  // Clamp a requested length into [LEN_MIN, pat_w].
  function automatic logic [4:0] clamp_len(input logic [4:0] len, input int pat_w);
    logic [4:0] r;
    if (int'(len) < LEN_MIN)
      r = 5'(LEN_MIN);
    else if (int'(len) > pat_w)
      r = 5'(pat_w);
    else
      r = len;
    return r;
  endfunction

endpackage

// File: rtl/seq_det_prog_sat_counter.sv
// Saturating up-counter: counts inc pulses, holds at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (inc && (cnt != {W{1'b1}}))
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/seq_det_prog.sv
// Programmable serial sequence detector with overlapping / non-overlapping modes.
// Define SEQ_DET_PROG_CNT_EN to build the saturating match counter; otherwise match_cnt is 0.
module seq_det_prog
  import seq_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] pat,
  input  logic [4:0]       len,
  input  logic             ovl,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt
);

  logic [PAT_W-1:0] pat_q;
  logic [4:0]       len_q;
  logic             ovl_q;
  logic [PAT_W-1:0] hist;
  logic [4:0]       fill;

  logic [PAT_W-1:0] hist_sh;
  logic [PAT_W-1:0] len_mask;
  logic [5:0]       fill_inc;
  logic [4:0]       fill_nxt;
  logic             hit;

  always_comb begin
    hist_sh  = {hist[PAT_W-2:0], din};
    // len_q never exceeds PAT_W, so a shift of PAT_W yields an all-ones mask.
    len_mask = ~({PAT_W{1'b1}} << len_q);
    fill_inc = {1'b0, fill} + 6'd1;
    fill_nxt = (fill_inc >= {1'b0, len_q}) ? len_q : fill_inc[4:0];
    hit      = en && !cfg_load && (fill_inc >= {1'b0, len_q}) &&
               ((hist_sh & len_mask) == (pat_q & len_mask));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q <= '0;
      len_q <= 5'(PAT_W);
      ovl_q <= MODE_OVL;
      hist  <= '0;
      fill  <= '0;
      match <= 1'b0;
    end else if (cfg_load) begin
      pat_q <= pat;
      len_q <= clamp_len(len, PAT_W);
      ovl_q <= ovl;
      hist  <= '0;
      fill  <= '0;
      match <= 1'b0;
    end else begin
      match <= hit;
      if (en) begin
        hist <= hist_sh;
        // Non-overlapping mode restarts collection after every hit.
        fill <= (hit && (ovl_q == MODE_NOVL)) ? 5'd0 : fill_nxt;
      end
    end
  end

`ifdef SEQ_DET_PROG_CNT_EN
  sat_counter #(.W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (hit),
    .cnt (match_cnt)
  );
`else
  assign match_cnt = {CNT_W{1'b0}};
`endif

endmodule
